// File: rtl/seven_segment_scan.sv
// Multiplexed hex driver for a common-anode seven-segment bank with dead time,
// leading-zero suppression and frame-synchronous (tear-free) display updates.
module seven_segment_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD           = 16,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  input  logic [DIGITS-1:0]     wr_blank,
  input  logic                  lz_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int PCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PCW-1:0]    PC_LAST  = PCW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = (ACTIVE_LOW_SEG != 0);
  localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW_AN != 0) ? '1 : '0;

  logic [PCW-1:0]      pc;
  logic [IW-1:0]       idx;
  logic                commit;

  logic [4*DIGITS-1:0] sh_val, disp_val;
  logic [DIGITS-1:0]   sh_dp, disp_dp;
  logic [DIGITS-1:0]   sh_blank, disp_blank;
  logic                pending;

  logic [3:0]          cur_val;
  logic                cur_dp, cur_blank, cur_supp, zero_run;
  logic [DIGITS-1:0]   onehot;
  logic                in_dead, dark;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;

  // Glyphs are stored active-low {g..a}; polarity is applied at the output.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign commit = (pc == PC_LAST) && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= '0;
    end else if (pc == PC_LAST) begin
      pc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      pc <= pc + PCW'(1);
    end
  end

  // A write landing on the commit edge bypasses the shadow set so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else begin
      if (wr_en) begin
        sh_val   <= wr_data;
        sh_dp    <= wr_dp;
        sh_blank <= wr_blank;
      end
      if (commit) begin
        pending <= 1'b0;
        if (wr_en) begin
          disp_val   <= wr_data;
          disp_dp    <= wr_dp;
          disp_blank <= wr_blank;
        end else if (pending) begin
          disp_val   <= sh_val;
          disp_dp    <= sh_dp;
          disp_blank <= sh_blank;
        end
      end else if (wr_en) begin
        pending <= 1'b1;
      end
    end
  end

  // Walk from the top digit down so zero_run marks "this and all higher digits are 0".
  always_comb begin
    cur_val   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    zero_run  = 1'b1;
    onehot    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_val[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        cur_val   = disp_val[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = disp_blank[k];
        cur_supp  = lz_en && zero_run && (k != 0);
        onehot[k] = 1'b1;
      end
    end
  end

  generate
    if (DEAD > 0) begin : g_dead
      assign in_dead = (pc < PCW'(DEAD));
    end else begin : g_nodead
      assign in_dead = 1'b0;
    end
  endgenerate

  always_comb begin
    dark    = cur_blank || cur_supp || in_dead;
    seg_nxt = SEG_OFF;
    dp_nxt  = DP_OFF;
    an_nxt  = AN_OFF;
    if (!dark) begin
      seg_nxt = (ACTIVE_LOW_SEG != 0) ? glyph(cur_val) : ~glyph(cur_val);
      dp_nxt  = cur_dp ? ~DP_OFF : DP_OFF;
      an_nxt  = (ACTIVE_LOW_AN != 0) ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
      an_out     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_nxt;
      dp_out     <= dp_nxt;
      an_out     <= an_nxt;
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed self-checking bench for seven_segment_scan (4 digits, 4-clock slots,
// 1 dead clock, active-low outputs); expected glyphs are hand-written constants.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_blank;
  logic        lz_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seven_segment_scan #(
    .DIGITS(4), .CLK_DIV(4), .DEAD(1), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .wr_blank(wr_blank), .lz_en(lz_en), .seg_out(seg_out), .dp_out(dp_out),
    .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle register write, driven on a falling edge.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    wr_en    = 1'b1;
    wr_data  = v;
    wr_dp    = d;
    wr_blank = b;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic waitFrame();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    checkOutput("wait_frame", {7'd0, frame_done}, 8'd1);
  endtask

  // Checks 16 output cycles; glyphs = {d3,d2,d1,d0}, the last cycle carries frame_done.
  task automatic checkFrame(input string name, input logic [27:0] glyphs,
                            input logic [3:0] lit, input logic [3:0] dps);
    int k;
    logic [3:0] oh;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    for (int c = 0; c < 16; c++) begin
      k = c / 4;
      @(negedge clk);
      if ((c % 4 == 0) || !lit[k]) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        oh      = 4'b0001 << k;
        exp_an  = ~oh;
        exp_seg = glyphs[k*7 +: 7];
        exp_dp  = ~dps[k];
      end
      checkOutput($sformatf("%s c%0d an", name, c), {4'd0, an_out}, {4'd0, exp_an});
      checkOutput($sformatf("%s c%0d seg", name, c), {1'b0, seg_out}, {1'b0, exp_seg});
      checkOutput($sformatf("%s c%0d dp", name, c), {7'd0, dp_out}, {7'd0, exp_dp});
      checkOutput($sformatf("%s c%0d fd", name, c), {7'd0, frame_done}, {7'd0, (c == 15)});
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, " seg"}, {1'b0, seg_out}, 8'h7F);
    checkOutput({name, " an"}, {4'd0, an_out}, 8'h0F);
    checkOutput({name, " dp"}, {7'd0, dp_out}, 8'd1);
    checkOutput({name, " fd"}, {7'd0, frame_done}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 16'h0;
    wr_dp    = 4'h0;
    wr_blank = 4'h0;
    lz_en    = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("por");
    rst_n = 1'b1;

    // All-zero display after reset, then live leading-zero suppression
    checkFrame("zero", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0);
    lz_en = 1'b1;
    checkFrame("zero_lz", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h1, 4'h0);
    lz_en = 1'b0;

    $display("[TB] hex decode");
    applyStimulus(16'hABCD, 4'h0, 4'h0);
    waitFrame();
    checkFrame("abcd", {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4'h0);

    $display("[TB] tear-free update");
    applyStimulus(16'h1234, 4'h0, 4'h0);
    repeat (4) @(negedge clk);
    applyStimulus(16'h5678, 4'h0, 4'h0);
    waitFrame();
    checkFrame("5678", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, 4'h0);
    repeat (15) @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 16'h9ABC;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("commit_edge_fd", {7'd0, frame_done}, 8'd1);
    checkFrame("9abc", {7'h10, 7'h08, 7'h03, 7'h46}, 4'hF, 4'h0);
    checkFrame("9abc_hold", {7'h10, 7'h08, 7'h03, 7'h46}, 4'hF, 4'h0);

    $display("[TB] mid-operation reset");
    #2 rst_n = 1'b0;
    #1 checkReset("mid_rst");
    @(negedge clk);
    checkReset("mid_rst_hold");
    rst_n = 1'b1;
    checkFrame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0);

    $display("[TB] leading-zero suppression");
    lz_en = 1'b1;
    applyStimulus(16'h0050, 4'h0, 4'h0);
    waitFrame();
    checkFrame("lz_0050", {7'h40, 7'h40, 7'h12, 7'h40}, 4'h3, 4'h0);
    applyStimulus(16'h0000, 4'h0, 4'h0);
    waitFrame();
    checkFrame("lz_0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h1, 4'h0);
    lz_en = 1'b0;

    $display("[TB] decimal point and blanking");
    applyStimulus(16'h8888, 4'b0010, 4'b1000);
    waitFrame();
    checkFrame("dp_blank", {7'h00, 7'h00, 7'h00, 7'h00}, 4'h7, 4'b0010);

    // Anode exclusivity and dead cycle at the start of every slot
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      checkOutput($sformatf("an_excl c%0d", c), {7'd0, ($countones(~an_out) <= 1)}, 8'd1);
      if (c % 4 == 0)
        checkOutput($sformatf("an_dead c%0d", c), {4'd0, an_out}, 8'h0F);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Time-multiplexed hexadecimal display driver for a common-anode multi-digit seven-segment bank on the board I/O path. It holds a `DIGITS`-nibble value written by the processor-side I/O logic and scans one digit at a time with a programmable slot length and anti-ghosting dead time. It adds full 0–F glyphs, per-digit decimal points and blanking, leading-zero suppression, and tear-free frame-synchronous updates.

## Interface
- `DIGITS`, 4: number of digits, 1–8.
- `CLK_DIV`, 50000: clocks per digit slot, ≥ 2.
- `DEAD`, 16: clocks at the start of each slot with all anodes off, 0 ≤ `DEAD` < `CLK_DIV`.
- `ACTIVE_LOW_SEG`, 1: 1 means segment and dp outputs are active-low; 0 means active-high.
- `ACTIVE_LOW_AN`, 1: 1 means anode outputs are active-low; 0 means active-high.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_en`  in  1  load shadow registers this cycle
- `wr_data`  in  4*DIGITS  digit values; nibble k is digit k, digit 0 is least significant/rightmost
- `wr_dp`  in  DIGITS  decimal-point enables, loaded with `wr_en`
- `wr_blank`  in  DIGITS  forced-blank mask, loaded with `wr_en`
- `lz_en`  in  1  leading-zero suppression enable, sampled live
- `seg_out`  out  7  {g,f,e,d,c,b,a}
- `dp_out`  out  1  decimal point
- `an_out`  out  DIGITS  digit anodes
- `frame_done`  out  1  one-cycle pulse per completed scan frame

## Operation
- **Registers**
  - Shadow set: `val`, `dp`, `blank`, plus a `pending` flag.
  - Display set: same fields.
  - Counters: prescaler `pc` (0..CLK_DIV-1) and digit index `idx` (0..DIGITS-1).
- **Writes**
  - `wr_en` loads the shadow set and sets `pending`.
  - Multiple writes within one frame: the last write wins.
- **Scan**
  - `pc` increments every cycle.
  - At `pc == CLK_DIV-1`, `pc` wraps to 0 and `idx` increments.
  - `idx` wraps from DIGITS-1 to 0.
- **Commit**
  - The commit edge is the edge where `pc == CLK_DIV-1` and `idx == DIGITS-1`.
  - At the commit edge, if `pending`: display set ← shadow set and `pending` clears.
  - If `wr_en` is also high on the commit edge, the display set takes `wr_*` directly and `pending` stays clear.
- **Decode** (active-low encodings, `{g..a}`): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. When `ACTIVE_LOW_SEG=0`, outputs are the bitwise inverse.
- **Leading-zero suppression**
  - Applies when `lz_en` is high.
  - Digit k is suppressed if it and every digit above it are 0.
  - Digit 0 is never suppressed.
- **Digit k is dark** if `blank[k]` is set, or it is suppressed, or `pc < DEAD`.
  - Dark digit: anode off, segments all off, dp off.
- **Lit digit:** anode k on, all other anodes off, `seg_out` = glyph, `dp_out` = `dp[k]`.

## Timing
- **Reset values** (while `rst_n` low, independent of `clk`):
  - `pc`=0, `idx`=0, all shadow and display fields 0, `pending`=0.
  - `seg_out` all off (7'h7F active-low), `dp_out` off, `an_out` all off, `frame_done`=0.
- **Output registration**
  - All outputs are registered: they reflect (`pc`, `idx`, display set) from the previous cycle, i.e. one clock of latency.
  - Therefore slot k is visible on the outputs for `CLK_DIV` cycles, starting one cycle after `idx` becomes k.
  - Anode k is on for the final `CLK_DIV-DEAD` cycles of that window.
- **`frame_done`** is high in the cycle after the commit edge, once per `DIGITS*CLK_DIV` clocks.
- **Write-to-display latency:** the new value is first visible in the slot-0 window following the next commit edge. Worst case ≈ `DIGITS*CLK_DIV+1` clocks.
- **Mid-operation reset:** state returns to reset values immediately. After release, scanning restarts at `idx=0` and the display shows 0 in every digit (only digit 0 when `lz_en`).
- **Anode exclusivity:** at most one anode is on in any cycle.

## Test plan
All scenarios use `DIGITS=4`, `CLK_DIV=4`, `DEAD=1`, active-low outputs.
1. **Reset:** assert `rst_n` low mid-frame → `seg_out`=7'h7F, `an_out`=4'hF, `dp_out`=1, `frame_done`=0 in the same cycle. After release, `frame_done` pulses every 16 clocks.
2. **Full hex decode:** write 16'hABCD, `lz_en`=0 → after the next `frame_done`, each slot shows 1 dark cycle then 3 cycles with one anode low:
   - digit 0: 0100001 (d)
   - digit 1: 1000110 (C)
   - digit 2: 0000011 (b)
   - digit 3: 0001000 (A)
3. **Tear-free update:** write 16'h1234, then 16'h5678 five cycles later within the same frame → 1234 is never displayed; 5678 appears after the next commit. A write on the commit edge itself appears in the very next frame.
4. **Leading-zero suppression:** write 16'h0050, `lz_en`=1 → digits 3 and 2 fully dark; digit 1 = 0010010, digit 0 = 1000000. Write 16'h0000 → only digit 0 lit (1000000).
5. **Decimal point and blanking:** `wr_dp`=4'b0010, `wr_blank`=4'b1000, value 16'h8888 → `dp_out`=0 only in the digit-1 lit cycles; digit 3's anode is never low; digits 0–2 show 0000000.
6. **Dead time and exclusivity:** across 64 clocks, `an_out` has at most one 0 bit per cycle and is 4'hF on the first output cycle of every slot.
